mipi_frame_checker: RTL and testbench
=====================================

Name: mipi_frame_checker

Overview:
- Sits directly downstream of the MIPI CSI-2 PHY wrapper in the camera pipeline.
- Consumes its 4-pixel RAW10 beat stream and sync strobes.
- Frames the stream into validated frames of H_PIXELS x V_LINES and forwards accepted beats to the image buffer FIFO write port.
- Aborts and counts malformed frames, and reports error causes to the host register map.

Parameters:
- H_PIXELS, 1920: active pixels per line; must be a multiple of 4.
- V_LINES, 1080: active lines per frame.
- CNT_W, 16: width of the frame statistics counters.

Ports:
- video_aclk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable from host register.
- pix_data  in  40  4 RAW10 pixels; pixel0 is bits [9:0].
- line_valid  in  1  beat valid; no backpressure upstream.
- sync_sof  in  1  first beat of frame; qualified by line_valid.
- sync_eol  in  1  last beat of line; qualified by line_valid.
- sync_eof  in  1  end-of-frame pulse; independent of line_valid.
- sync_error  in  1  SoT sync error pulse.
- fifo_full  in  1  downstream FIFO full.
- out_data  out  40  forwarded beat.
- out_wr  out  1  FIFO write strobe.
- out_sof  out  1  marks first beat of frame; qualified by out_wr.
- out_eol  out  1  marks last beat of line; qualified by out_wr.
- out_abort  out  1  1-cycle pulse: current frame discarded; downstream rewinds.
- frame_done  out  1  1-cycle pulse: frame completed correctly.
- frame_err  out  1  1-cycle pulse: frame aborted.
- err_code  out  3  cause of last abort; sticky until next abort.
- frames_ok  out  CNT_W  good-frame count; saturating.
- frames_dropped  out  CNT_W  aborted-frame count; saturating.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal beat and line counters 0.
- Datapath: fully registered. out_* follow the accepted input beat by exactly 1 cycle, so out_wr = line_valid accepted in ACTIVE, delayed one cycle.
- Beats per line: BPL = H_PIXELS/4. Beat counter is log2-sized; line counter counts completed lines.

FSM states:
- IDLE: outputs quiet. enable=1 -> WAIT_SOF.
- WAIT_SOF: discard beats. When line_valid & sync_sof: accept the beat, beat cnt=1, line cnt=0 -> ACTIVE.
- ACTIVE: each line_valid beat is forwarded and beat cnt increments.
  - On sync_eol: beat cnt must equal BPL. Then beat cnt=0 and line cnt increments.
  - On sync_eof: line cnt must equal V_LINES. Then frame_done pulse, frames_ok++ -> WAIT_SOF.
- DROP: discard everything until sync_eof -> WAIT_SOF.

Errors in ACTIVE, with err_code value:
- 1 short line: sync_eol with beat cnt+1 < BPL.
- 2 long line: beat arrives with beat cnt = BPL.
- 3 line count: sync_eof with line cnt != V_LINES.
- 4 overflow: line_valid while fifo_full.
- 5 sync_error.
- 6 sof inside frame: sync_sof seen while ACTIVE.

Error action:
- Next cycle: frame_err=1 and out_abort=1, err_code updated, frames_dropped++.
- The offending beat is not forwarded.
- Codes 1, 2, 4, 5 -> DROP. Code 3 -> WAIT_SOF.
- Code 6: the aborting beat restarts a new frame — forwarded with out_sof, stay ACTIVE, counters reset to beat=1, line=0.

Simultaneous events:
- eol and eof on the same cycle: evaluate the beat and eol first, then the line-count check uses the incremented count.
- Multiple errors on the same cycle: lowest code wins.
- sync_error in IDLE, WAIT_SOF or DROP: ignored.

Enable and counters:
- enable=0 mid-frame: -> IDLE next cycle. out_abort pulses if the FSM was ACTIVE. frames_dropped is not incremented.
- Counters hold at 2^CNT_W-1. They are cleared only by reset.

Optional Feature:
- MIPI_FRAME_CHECKER_STATS_EN defined: adds outputs last_line_beats [15:0] and last_frame_lines [15:0].
  - last_line_beats holds the beat count of the most recent line at eol, including short lines.
  - last_frame_lines holds the line count of the most recent frame at eof or abort.
  - Both reset to 0 and are updated 1 cycle after the event.
- Undefined: ports absent, no extra logic.

Test Plan:
- Small config (H_PIXELS=16, V_LINES=3, BPL=4), enable=1, one clean frame (sof, 3 lines of 4 beats with eol, eof) -> 12 out_wr; out_sof on beat 1; 3 out_eol; frame_done 1 pulse; frames_ok=1; frames_dropped=0.
- Line 2 with eol on beat 3 -> frame_err, out_abort, err_code=1; rest of frame discarded until eof; next clean frame accepted, frames_ok=1, frames_dropped=1.
- fifo_full held during beat 6 of a clean frame -> that beat not written; err_code=4; DROP until eof.
- Only 2 lines then eof -> err_code=3; returns to WAIT_SOF with no DROP; the following frame is accepted.
- sof mid-line-1 of an active frame -> err_code=6, out_abort, and the same beat emitted next cycle with out_sof; the new frame completes with frame_done.
- Frames arriving before enable, plus deassert enable mid-frame -> no out_wr while disabled; out_abort once; counters unchanged; async reset mid-frame clears all outputs immediately.

Source files
------------

// File: rtl/mipi_frame_checker.sv
// Frame checker for the CSI-2 RAW10 beat stream: validates line/frame geometry, forwards good beats, aborts bad frames.
// Define MIPI_FRAME_CHECKER_STATS_EN to add the last_line_beats / last_frame_lines statistics outputs.
module mipi_frame_checker #(
  parameter int H_PIXELS = 1920,
  parameter int V_LINES  = 1080,
  parameter int CNT_W    = 16
) (
  input  logic             video_aclk,
  input  logic             reset,
  input  logic             enable,
  input  logic [39:0]      pix_data,
  input  logic             line_valid,
  input  logic             sync_sof,
  input  logic             sync_eol,
  input  logic             sync_eof,
  input  logic             sync_error,
  input  logic             fifo_full,
  output logic [39:0]      out_data,
  output logic             out_wr,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_abort,
  output logic             frame_done,
  output logic             frame_err,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_dropped
`ifdef MIPI_FRAME_CHECKER_STATS_EN
  ,
  output logic [15:0]      last_line_beats,
  output logic [15:0]      last_frame_lines
`endif
);

  localparam int BPL    = H_PIXELS / 4;
  localparam int BEAT_W = $clog2(BPL + 1);
  // One spare code above V_LINES so surplus lines saturate instead of wrapping back to a legal count.
  localparam int LINE_W = $clog2(V_LINES + 2);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BPL - 1);
  localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(BPL);
  localparam logic [LINE_W-1:0] LINE_DONE = LINE_W'(V_LINES);
  localparam logic [LINE_W-1:0] LINE_SAT  = LINE_W'(V_LINES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE,
    DROP
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE         = 3'd0,
    ERR_SHORT_LINE   = 3'd1,
    ERR_LONG_LINE    = 3'd2,
    ERR_LINE_COUNT   = 3'd3,
    ERR_OVERFLOW     = 3'd4,
    ERR_SYNC         = 3'd5,
    ERR_SOF_IN_FRAME = 3'd6
  } err_t;

  state_t             state_q, state_d;
  logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0]  line_cnt_q, line_cnt_d;
  logic [39:0]        out_data_q, out_data_d;
  logic               out_wr_q, out_wr_d;
  logic               out_sof_q, out_sof_d;
  logic               out_eol_q, out_eol_d;
  logic               out_abort_q, out_abort_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;
  err_t               err_code_q, err_code_d;
  logic [CNT_W-1:0]   frames_ok_q, frames_ok_d;
  logic [CNT_W-1:0]   frames_dropped_q, frames_dropped_d;
`ifdef MIPI_FRAME_CHECKER_STATS_EN
  logic [15:0]        last_line_beats_q, last_line_beats_d;
  logic [15:0]        last_frame_lines_q, last_frame_lines_d;
`endif

  // Per-beat checks while ACTIVE
  logic              short_line;
  logic              long_line;
  logic              line_end;
  logic [LINE_W-1:0] line_cnt_eff;
  err_t              err_cause;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    short_line   = line_valid && sync_eol && (beat_cnt_q < BEAT_LAST);
    long_line    = line_valid && (beat_cnt_q == BEAT_FULL);
    line_end     = line_valid && sync_eol && !short_line && !long_line;
    line_cnt_eff = line_cnt_q;
    if (line_end && (line_cnt_q != LINE_SAT)) begin
      line_cnt_eff = line_cnt_q + 1'b1;
    end

    // The end-of-frame line check sees the count already bumped by a same-cycle eol.
    err_cause = ERR_NONE;
    if (short_line) begin
      err_cause = ERR_SHORT_LINE;
    end else if (long_line) begin
      err_cause = ERR_LONG_LINE;
    end else if (sync_eof && (line_cnt_eff != LINE_DONE)) begin
      err_cause = ERR_LINE_COUNT;
    end else if (line_valid && fifo_full) begin
      err_cause = ERR_OVERFLOW;
    end else if (sync_error) begin
      err_cause = ERR_SYNC;
    end else if (line_valid && sync_sof) begin
      err_cause = ERR_SOF_IN_FRAME;
    end
  end

  always_comb begin
    state_d          = state_q;
    beat_cnt_d       = beat_cnt_q;
    line_cnt_d       = line_cnt_q;
    out_data_d       = out_data_q;
    out_wr_d         = 1'b0;
    out_sof_d        = 1'b0;
    out_eol_d        = 1'b0;
    out_abort_d      = 1'b0;
    frame_done_d     = 1'b0;
    frame_err_d      = 1'b0;
    err_code_d       = err_code_q;
    frames_ok_d      = frames_ok_q;
    frames_dropped_d = frames_dropped_q;
`ifdef MIPI_FRAME_CHECKER_STATS_EN
    last_line_beats_d  = last_line_beats_q;
    last_frame_lines_d = last_frame_lines_q;
`endif

    if (!enable) begin
      // Host disable is not a stream fault: abort the frame but leave err_code and frames_dropped alone.
      state_d     = IDLE;
      out_abort_d = (state_q == ACTIVE);
`ifdef MIPI_FRAME_CHECKER_STATS_EN
      if (state_q == ACTIVE) begin
        last_frame_lines_d = 16'(line_cnt_q);
      end
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT_SOF;
        end

        WAIT_SOF: begin
          // A frame start that lands on a full FIFO is skipped rather than overflowing it.
          if (line_valid && sync_sof && !fifo_full) begin
            out_wr_d   = 1'b1;
            out_sof_d  = 1'b1;
            out_data_d = pix_data;
            beat_cnt_d = BEAT_W'(1);
            line_cnt_d = '0;
            state_d    = ACTIVE;
          end
        end

        ACTIVE: begin
`ifdef MIPI_FRAME_CHECKER_STATS_EN
          if (line_valid && sync_eol) begin
            last_line_beats_d = 16'(beat_cnt_q) + 16'd1;
          end
`endif
          if (err_cause == ERR_NONE) begin
            if (line_valid) begin
              out_wr_d   = 1'b1;
              out_eol_d  = sync_eol;
              out_data_d = pix_data;
              beat_cnt_d = sync_eol ? '0 : beat_cnt_q + 1'b1;
              line_cnt_d = line_cnt_eff;
            end
            if (sync_eof) begin
              frame_done_d = 1'b1;
              frames_ok_d  = (frames_ok_q == CNT_MAX) ? frames_ok_q : frames_ok_q + 1'b1;
              state_d      = WAIT_SOF;
`ifdef MIPI_FRAME_CHECKER_STATS_EN
              last_frame_lines_d = 16'(line_cnt_eff);
`endif
            end
          end else begin
            out_abort_d      = 1'b1;
            frame_err_d      = 1'b1;
            err_code_d       = err_cause;
            frames_dropped_d = (frames_dropped_q == CNT_MAX) ? frames_dropped_q
                                                             : frames_dropped_q + 1'b1;
`ifdef MIPI_FRAME_CHECKER_STATS_EN
            last_frame_lines_d = (err_cause == ERR_LINE_COUNT) ? 16'(line_cnt_eff)
                                                               : 16'(line_cnt_q);
`endif
            case (err_cause)
              ERR_LINE_COUNT: state_d = WAIT_SOF;
              ERR_SOF_IN_FRAME: begin
                // The intruding start beat becomes beat 1 of a fresh frame.
                out_wr_d   = 1'b1;
                out_sof_d  = 1'b1;
                out_data_d = pix_data;
                beat_cnt_d = BEAT_W'(1);
                line_cnt_d = '0;
              end
              // A frame that also ends on this cycle has nothing left to discard.
              default: state_d = sync_eof ? WAIT_SOF : DROP;
            endcase
          end
        end

        DROP: begin
          if (sync_eof) begin
            state_d = WAIT_SOF;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge video_aclk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      beat_cnt_q       <= '0;
      line_cnt_q       <= '0;
      out_data_q       <= '0;
      out_wr_q         <= 1'b0;
      out_sof_q        <= 1'b0;
      out_eol_q        <= 1'b0;
      out_abort_q      <= 1'b0;
      frame_done_q     <= 1'b0;
      frame_err_q      <= 1'b0;
      err_code_q       <= ERR_NONE;
      frames_ok_q      <= '0;
      frames_dropped_q <= '0;
`ifdef MIPI_FRAME_CHECKER_STATS_EN
      last_line_beats_q  <= '0;
      last_frame_lines_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      line_cnt_q       <= line_cnt_d;
      out_data_q       <= out_data_d;
      out_wr_q         <= out_wr_d;
      out_sof_q        <= out_sof_d;
      out_eol_q        <= out_eol_d;
      out_abort_q      <= out_abort_d;
      frame_done_q     <= frame_done_d;
      frame_err_q      <= frame_err_d;
      err_code_q       <= err_code_d;
      frames_ok_q      <= frames_ok_d;
      frames_dropped_q <= frames_dropped_d;
`ifdef MIPI_FRAME_CHECKER_STATS_EN
      last_line_beats_q  <= last_line_beats_d;
      last_frame_lines_q <= last_frame_lines_d;
`endif
    end
  end

  assign out_data       = out_data_q;
  assign out_wr         = out_wr_q;
  assign out_sof        = out_sof_q;
  assign out_eol        = out_eol_q;
  assign out_abort      = out_abort_q;
  assign frame_done     = frame_done_q;
  assign frame_err      = frame_err_q;
  assign err_code       = err_code_q;
  assign frames_ok      = frames_ok_q;
  assign frames_dropped = frames_dropped_q;
`ifdef MIPI_FRAME_CHECKER_STATS_EN
  assign last_line_beats  = last_line_beats_q;
  assign last_frame_lines = last_frame_lines_q;
`endif

endmodule

// File: tb/tb_mipi_frame_checker.sv
// Directed table-driven bench for mipi_frame_checker in a 16x3 configuration (4 beats per line, 3-bit counters).
module tb_mipi_frame_checker;

  localparam int H_PIXELS = 16;
  localparam int V_LINES  = 3;
  localparam int CNT_W    = 3;

  logic             video_aclk = 1'b0;
  logic             reset;
  logic             enable;
  logic [39:0]      pix_data;
  logic             line_valid;
  logic             sync_sof;
  logic             sync_eol;
  logic             sync_eof;
  logic             sync_error;
  logic             fifo_full;
  logic [39:0]      out_data;
  logic             out_wr;
  logic             out_sof;
  logic             out_eol;
  logic             out_abort;
  logic             frame_done;
  logic             frame_err;
  logic [2:0]       err_code;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] frames_dropped;
`ifdef MIPI_FRAME_CHECKER_STATS_EN
  logic [15:0]      last_line_beats;
  logic [15:0]      last_frame_lines;
`endif

  always #5 video_aclk = ~video_aclk;

  mipi_frame_checker #(
    .H_PIXELS(H_PIXELS),
    .V_LINES (V_LINES),
    .CNT_W   (CNT_W)
  ) dut (
    .video_aclk    (video_aclk),
    .reset         (reset),
    .enable        (enable),
    .pix_data      (pix_data),
    .line_valid    (line_valid),
    .sync_sof      (sync_sof),
    .sync_eol      (sync_eol),
    .sync_eof      (sync_eof),
    .sync_error    (sync_error),
    .fifo_full     (fifo_full),
    .out_data      (out_data),
    .out_wr        (out_wr),
    .out_sof       (out_sof),
    .out_eol       (out_eol),
    .out_abort     (out_abort),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .err_code      (err_code),
    .frames_ok     (frames_ok),
    .frames_dropped(frames_dropped)
`ifdef MIPI_FRAME_CHECKER_STATS_EN
    ,
    .last_line_beats (last_line_beats),
    .last_frame_lines(last_frame_lines)
`endif
  );

  typedef struct packed {
    logic en, lv, sof, eol, eof, serr, full;
  } in_t;

  typedef struct packed {
    logic       wr, sof, eol, abort, done, err;
    logic [2:0] code, ok, drop;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t       vecs[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [2:0] ok_e     = '0;
  logic [2:0] drop_e   = '0;
  logic [2:0] code_e   = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [2:0] sat(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  function automatic in_t mk(input logic en, lv, sof, eol, eof, serr, full);
    in_t r;
    r.en = en; r.lv = lv; r.sof = sof; r.eol = eol; r.eof = eof; r.serr = serr; r.full = full;
    return r;
  endfunction

  function automatic logic [39:0] pix_for(input int k);
    return 40'h5A_0000_0000 | 40'(k);
  endfunction

  task automatic add(input in_t i, input logic wr, osof, oeol, abort, done, err);
    vec_t v;
    v.i      = i;
    v.o.wr   = wr;   v.o.sof  = osof; v.o.eol = oeol;
    v.o.abort = abort; v.o.done = done; v.o.err = err;
    v.o.code = code_e; v.o.ok = ok_e; v.o.drop = drop_e;
    vecs.push_back(v);
  endtask

  task automatic quiet(input in_t i);
    add(i, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input logic sof, input logic eol);
    add(mk(1, 1, sof, eol, 0, 0, 0), 1, sof, eol, 0, 0, 0);
  endtask

  task automatic full_line(input logic first);
    for (int b = 0; b < 4; b++) beat(first && (b == 0), b == 3);
  endtask

  task automatic eof_done();
    ok_e = sat(ok_e);
    add(mk(1, 0, 0, 0, 1, 0, 0), 0, 0, 0, 0, 1, 0);
  endtask

  task automatic good_frame(input logic eof_on_last);
    full_line(1);
    full_line(0);
    if (eof_on_last) begin
      for (int b = 0; b < 3; b++) beat(0, 0);
      ok_e = sat(ok_e);
      add(mk(1, 1, 0, 1, 1, 0, 0), 1, 0, 1, 0, 1, 0);
    end else begin
      full_line(0);
      eof_done();
    end
  endtask

  task automatic abort_row(input in_t i, input logic [2:0] code, input logic fwd_sof);
    code_e = code;
    drop_e = sat(drop_e);
    add(i, fwd_sof, fwd_sof, 0, 1, 0, 1);
  endtask

  task automatic drive(input in_t i, input logic [39:0] pix);
    enable     = i.en;
    line_valid = i.lv;
    sync_sof   = i.sof;
    sync_eol   = i.eol;
    sync_eof   = i.eof;
    sync_error = i.serr;
    fifo_full  = i.full;
    pix_data   = pix;
  endtask

  function automatic out_t sample();
    out_t s;
    s.wr = out_wr; s.sof = out_sof; s.eol = out_eol; s.abort = out_abort;
    s.done = frame_done; s.err = frame_err; s.code = err_code;
    s.ok = frames_ok; s.drop = frames_dropped;
    return s;
  endfunction

  initial begin
    // Traffic before enable and sync_error while idle are ignored.
    quiet(mk(0, 1, 1, 0, 0, 0, 0));
    quiet(mk(0, 1, 0, 1, 0, 1, 0));
    quiet(mk(0, 0, 0, 0, 1, 0, 0));
    // Enable rising: IDLE needs one cycle to reach WAIT_SOF, so this sof is not taken.
    quiet(mk(1, 1, 1, 0, 0, 0, 0));
    quiet(mk(1, 1, 0, 1, 0, 0, 0));
    quiet(mk(1, 0, 0, 0, 0, 1, 0));
    good_frame(0);                                  // ok=1

    // Short line: eol on the 3rd beat of line 2, then DROP until eof.
    full_line(1); beat(0, 0); beat(0, 0);
    abort_row(mk(1, 1, 0, 1, 0, 0, 0), 3'd1, 0);    // drop=1
    quiet(mk(1, 1, 0, 0, 0, 0, 0));
    quiet(mk(1, 1, 0, 1, 0, 0, 0));
    quiet(mk(1, 1, 1, 0, 0, 1, 0));
    quiet(mk(1, 0, 0, 0, 1, 0, 0));
    good_frame(0);                                  // ok=2

    // FIFO full on beat 6.
    full_line(1); beat(0, 0);
    abort_row(mk(1, 1, 0, 0, 0, 0, 1), 3'd4, 0);    // drop=2
    quiet(mk(1, 1, 0, 0, 0, 0, 0));
    quiet(mk(1, 1, 0, 1, 0, 0, 0));
    quiet(mk(1, 0, 0, 0, 1, 0, 0));

    // Two lines then eof: back to WAIT_SOF directly, next frame (eol+eof same beat) accepted.
    full_line(1); full_line(0);
    abort_row(mk(1, 0, 0, 0, 1, 0, 0), 3'd3, 0);    // drop=3
    good_frame(1);                                  // ok=3

    // sof on beat 3 of line 1 restarts the frame with that beat.
    beat(1, 0); beat(0, 0);
    abort_row(mk(1, 1, 1, 0, 0, 0, 0), 3'd6, 1);    // drop=4
    beat(0, 0); beat(0, 0); beat(0, 1);
    full_line(0); full_line(0);
    eof_done();                                     // ok=4

    // Long line: fifth beat without eol.
    beat(1, 0); beat(0, 0); beat(0, 0); beat(0, 0);
    abort_row(mk(1, 1, 0, 0, 0, 0, 0), 3'd2, 0);    // drop=5
    quiet(mk(1, 0, 0, 0, 1, 0, 0));

    // Overflow, sync_error and sof together: lowest code (4) wins.
    beat(1, 0);
    abort_row(mk(1, 1, 1, 0, 0, 1, 1), 3'd4, 0);    // drop=6
    quiet(mk(1, 0, 0, 0, 1, 0, 0));

    // Lone sync_error.
    beat(1, 0);
    abort_row(mk(1, 0, 0, 0, 0, 1, 0), 3'd5, 0);    // drop=7
    quiet(mk(1, 0, 0, 0, 1, 0, 0));

    // Short line with fifo_full: code 1 wins; dropped counter holds at 7.
    beat(1, 0);
    abort_row(mk(1, 1, 0, 1, 0, 0, 1), 3'd1, 0);    // drop stays 7
    quiet(mk(1, 0, 0, 0, 1, 0, 0));

    // Disable mid-frame: one abort pulse, no frame_err, counters and err_code untouched.
    beat(1, 0); beat(0, 0);
    add(mk(0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 0);
    quiet(mk(0, 1, 1, 0, 0, 0, 0));
    quiet(mk(0, 0, 0, 0, 1, 0, 0));
    quiet(mk(1, 1, 1, 0, 0, 0, 0));
    quiet(mk(1, 1, 0, 1, 0, 0, 0));

    // Good-frame counter runs into saturation at 7.
    for (int f = 0; f < 4; f++) good_frame(f[0]);  // ok 5,6,7,7

    // Reset state.
    drive(mk(0, 0, 0, 0, 0, 0, 0), '0);
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge video_aclk);
    #1;
    check("reset outputs {wr sof eol abort done err code ok drop}", 64'(sample()), 64'd0);
    check("reset out_data", 64'(out_data), 64'd0);
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].i, pix_for(k));
      @(posedge video_aclk);
      #1;
      check($sformatf("row %0d {wr sof eol abort done err code ok drop}", k),
            64'(sample()), 64'(vecs[k].o));
      if (vecs[k].o.wr) check($sformatf("row %0d out_data", k), 64'(out_data), 64'(pix_for(k)));
    end

    // Asynchronous reset mid-frame clears outputs before any clock edge.
    drive(mk(1, 1, 1, 0, 0, 0, 0), 40'h00_1234_5678);
    @(posedge video_aclk);
    #1;
    check("pre-reset out_wr", 64'(out_wr), 64'd1);
    check("pre-reset frames_ok", 64'(frames_ok), 64'd7);
    drive(mk(1, 1, 0, 0, 0, 0, 0), 40'h00_8765_4321);
    #2 reset = 1'b1;
    #1;
    check("async reset outputs {wr sof eol abort done err code ok drop}", 64'(sample()), 64'd0);
    check("async reset out_data", 64'(out_data), 64'd0);
    @(posedge video_aclk);
    #1;
    reset = 1'b0;
    drive(mk(1, 1, 1, 0, 0, 0, 0), 40'h00_0000_00AA);
    @(posedge video_aclk);
    #1;
    check("post-reset IDLE ignores sof", 64'(out_wr), 64'd0);
    drive(mk(1, 1, 1, 0, 0, 0, 0), 40'h00_0000_00BB);
    @(posedge video_aclk);
    #1;
    check("post-reset sof accepted {wr sof}", 64'({out_wr, out_sof}), 64'd3);
    check("post-reset out_data", 64'(out_data), 64'h00_0000_00BB);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
